// File: rtl/uart_tx_arbiter_pkg.sv
// Shared definitions for the two-requester UART transmit arbiter:
// requester count, byte width, FSM state encoding and the latched frame record.
package uart_tx_arbiter_pkg;

    localparam int NUM_REQ = 2;
    localparam int BYTE_W  = 8;
    localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND      = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    // Byte and owner captured on the accept cycle, held for the whole frame.
    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [BYTE_W-1:0] data;
    } frame_t;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester and transmitter handshake bundle for uart_tx_arbiter.
// master = arbiter side, slave = requesters plus UART transmitter.
interface uart_tx_arbiter_if;
    import uart_tx_arbiter_pkg::*;

    logic [NUM_REQ-1:0] req_valid;
    logic [BYTE_W-1:0]  req_data0;
    logic [BYTE_W-1:0]  req_data1;
    logic [NUM_REQ-1:0] req_ready;
    logic               tx_send;
    logic [BYTE_W-1:0]  tx_data;
    logic               tx_active;
    logic               tx_done;
    logic [ID_W-1:0]    grant_id;
    logic               busy;
    logic               err_timeout;

    modport master (
        input  req_valid, req_data0, req_data1, tx_active, tx_done,
        output req_ready, tx_send, tx_data, grant_id, busy, err_timeout
    );

    modport slave (
        output req_valid, req_data0, req_data1, tx_active, tx_done,
        input  req_ready, tx_send, tx_data, grant_id, busy, err_timeout
    );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Round-robin picker: searches upward from the requester after 'last',
// so the most recently served requester has lowest priority.
module uart_rr_pick
    import uart_tx_arbiter_pkg::*;
#(
    parameter  int N  = NUM_REQ,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic          gnt_vld,
    output logic [IW-1:0] gnt_idx
);

    logic [IW-1:0] cand;

    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int k = 1; k <= N; k++) begin
            cand = IW'((int'(last) + k) % N);
            if (!gnt_vld && req[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Arbitrates two byte requesters onto one UART transmitter, one frame at a time.
// Define TX_TIMEOUT_EN to build the SEND/WAIT_DONE abort counter (TIMEOUT_CYCLES).
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic              clock,
    input  logic              reset_n,
    uart_tx_arbiter_if.master bus
);

    state_t                         state, state_nx;
    frame_t                         cur;
    logic [ID_W-1:0]                last_grant;
    logic [NUM_REQ-1:0][BYTE_W-1:0] req_data;
    logic                           pick_vld;
    logic [ID_W-1:0]                pick_idx;
    logic                           accept;
    logic                           frame_end;
    logic                           tmo_hit;
    logic                           busy;

    assign req_data[0] = bus.req_data0;
    assign req_data[1] = bus.req_data1;

    uart_rr_pick #(.N(NUM_REQ)) u_pick (
        .req     (bus.req_valid),
        .last    (last_grant),
        .gnt_vld (pick_vld),
        .gnt_idx (pick_idx)
    );

    assign busy = (state != IDLE);

    // reset_n gates accept so req_ready is forced low while reset is held.
    always_comb begin
        state_nx  = state;
        accept    = 1'b0;
        frame_end = 1'b0;
        unique case (state)
            IDLE: begin
                if (pick_vld && reset_n) begin
                    accept   = 1'b1;
                    state_nx = SEND;
                end
            end
            SEND: begin
                if (bus.tx_active) state_nx = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (bus.tx_done && !bus.tx_active) begin
                    state_nx  = IDLE;
                    frame_end = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
        if (tmo_hit) begin
            state_nx  = IDLE;
            frame_end = 1'b1;
        end
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_rdy
        assign bus.req_ready[g] = accept && (pick_idx == ID_W'(g));
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            cur        <= '0;
            last_grant <= '1;
        end else begin
            state <= state_nx;
            if (accept)    cur        <= '{id: pick_idx, data: req_data[pick_idx]};
            if (frame_end) last_grant <= cur.id;
        end
    end

    assign bus.tx_send  = (state == SEND);
    assign bus.tx_data  = cur.data;
    assign bus.grant_id = cur.id;
    assign bus.busy     = busy;

`ifdef TX_TIMEOUT_EN
    localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [TMO_W-1:0] tmo_cnt;
    logic             err_q;

    // Counter starts at 0 on the first SEND cycle; the abort pulse is
    // registered so it appears on the cycle the FSM is back in IDLE.
    assign tmo_hit = busy && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tmo_cnt <= '0;
            err_q   <= 1'b0;
        end else begin
            err_q <= tmo_hit;
            if (accept)    tmo_cnt <= '0;
            else if (busy) tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
    end

    assign bus.err_timeout = err_q;
`else
    logic unused_tmo_cfg;

    assign unused_tmo_cfg  = (TIMEOUT_CYCLES > 0);
    assign tmo_hit         = 1'b0;
    assign bus.err_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: frame-level reference model checked
// every cycle, plus literal expectations on handshakes and the sent-frame log.
module tb_uart_tx_arbiter;
    import uart_tx_arbiter_pkg::*;

    localparam int TMO = 16;
`ifdef TX_TIMEOUT_EN
    localparam bit TMO_ON = 1'b1;
`else
    localparam bit TMO_ON = 1'b0;
`endif

    logic clock;
    logic reset_n;

    uart_tx_arbiter_if bus();

    uart_tx_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int         applied;
    int         miscompares;
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic [8:0] flog[$];
    logic [1:0] rdy_seen;
    logic       prev_send;

    // Reference model: is a frame in flight, has the transmitter started it,
    // who owns it, what byte, who was served last, how old the frame is.
    logic       m_fly, m_act, m_own, m_last, m_err;
    logic [7:0] m_byte;
    int         m_age;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        applied++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @%0t: got %0h want %0h", nm, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic model_step();
        logic       win, anyv, hit;
        logic [1:0] e_rdy;
        if (!reset_n) begin
            m_fly = 0; m_act = 0; m_own = 0; m_byte = 8'h00;
            m_last = 1; m_err = 0; m_age = 0;
        end
        anyv  = |bus.req_valid;
        win   = (bus.req_valid == 2'b11) ? !m_last : bus.req_valid[1];
        e_rdy = (reset_n && !m_fly && anyv) ? (win ? 2'b10 : 2'b01) : 2'b00;
        chk("req_ready",   bus.req_ready,   e_rdy);
        chk("busy",        bus.busy,        m_fly);
        chk("tx_send",     bus.tx_send,     m_fly && !m_act);
        chk("tx_data",     bus.tx_data,     m_byte);
        chk("grant_id",    bus.grant_id,    m_own);
        chk("err_timeout", bus.err_timeout, m_err);
        if (bus.tx_send && !prev_send) flog.push_back({bus.grant_id, bus.tx_data});
        prev_send = bus.tx_send;
        rdy_seen  = bus.req_ready;
        if (reset_n) begin
            hit = 0;
            if (!m_fly) begin
                if (anyv) begin
                    m_fly = 1; m_act = 0; m_own = win; m_age = 0;
                    m_byte = win ? bus.req_data1 : bus.req_data0;
                end
            end else begin
                if (TMO_ON && m_age == TMO - 1) begin
                    m_fly = 0; m_last = m_own; hit = 1;
                end else if (!m_act) begin
                    m_act = bus.tx_active;
                end else if (bus.tx_done && !bus.tx_active) begin
                    m_fly = 0; m_last = m_own;
                end
                m_age++;
            end
            m_err = hit;
        end
    endtask

    // Requesters hold valid/data until they see their ready bit.
    task automatic drive_req();
        if (rdy_seen[0] && q0.size() > 0) q0.delete(0);
        if (rdy_seen[1] && q1.size() > 0) q1.delete(0);
        rdy_seen      = 2'b00;
        bus.req_valid = {q1.size() > 0, q0.size() > 0};
        bus.req_data0 = (q0.size() > 0) ? q0[0] : 8'h00;
        bus.req_data1 = (q1.size() > 0) ? q1[0] : 8'h00;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        q0.delete(); q1.delete();
        rdy_seen = 2'b00;
        bus.tx_active = 1'b0;
        bus.tx_done   = 1'b0;
        tick(); tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic wait_send(input string nm);
        int n;
        n = 0;
        while (bus.tx_send !== 1'b1 && n < 64) begin
            tick();
            n++;
        end
        chk(nm, bus.tx_send, 1'b1);
    endtask

    // Transmitter: starts lat cycles after tx_send, active 2 cycles, then done.
    task automatic xmit(input int lat);
        wait_send("send_seen");
        repeat (lat) tick();
        bus.tx_active = 1'b1;
        tick(); tick();
        bus.tx_active = 1'b0;
        bus.tx_done   = 1'b1;
        tick();
        bus.tx_done   = 1'b0;
    endtask

    initial begin
        int n;
        applied = 0; miscompares = 0;
        reset_n = 1'b0;
        bus.req_valid = 2'b00; bus.req_data0 = 8'h00; bus.req_data1 = 8'h00;
        bus.tx_active = 1'b0;  bus.tx_done = 1'b0;
        rdy_seen = 2'b00; prev_send = 1'b0;
        fork
            forever begin @(negedge clock); model_step(); end
            forever begin @(posedge clock); #2; drive_req(); end
        join_none

        // Reset state
        do_reset();
        chk("rst_busy",    bus.busy,      1'b0);
        chk("rst_tx_data", bus.tx_data,   8'h00);
        chk("rst_grant",   bus.grant_id,  1'b0);
        chk("rst_send",    bus.tx_send,   1'b0);
        chk("rst_err",     bus.err_timeout, 1'b0);

        // Contest from reset: requester 0 first, then strict alternation
        flog.delete();
        q0.push_back(8'h11); q0.push_back(8'h33);
        q1.push_back(8'h22); q1.push_back(8'h44);
        #3;
        chk("contest_rdy", bus.req_ready, 2'b01);
        repeat (4) xmit(1);
        tick();
        chk("contest_n",  flog.size(), 4);
        chk("contest_f0", flog[0], 9'h011);
        chk("contest_f1", flog[1], 9'h122);
        chk("contest_f2", flog[2], 9'h033);
        chk("contest_f3", flog[3], 9'h144);

        // Single request
        do_reset();
        q0.push_back(8'hA5);
        #3;
        chk("single_rdy", bus.req_ready, 2'b01);
        tick();
        chk("single_data", bus.tx_data,   8'hA5);
        chk("single_send", bus.tx_send,   1'b1);
        chk("single_rdy0", bus.req_ready, 2'b00);
        chk("single_busy", bus.busy,      1'b1);
        xmit(2);
        chk("single_idle", bus.busy, 1'b0);

        // Stale done held through SEND must not end the frame
        do_reset();
        bus.tx_done = 1'b1;
        q0.push_back(8'h77);
        wait_send("stale_send");
        repeat (10) tick();
        chk("stale_busy", bus.busy,    1'b1);
        chk("stale_send", bus.tx_send, 1'b1);
        bus.tx_active = 1'b1;
        tick();
        chk("stale_wait_send", bus.tx_send, 1'b0);
        chk("stale_wait_busy", bus.busy,    1'b1);
        tick();
        chk("stale_active_hold", bus.busy, 1'b1);
        bus.tx_active = 1'b0;
        tick();
        chk("stale_exit", bus.busy, 1'b0);
        bus.tx_done = 1'b0;

        // Reset in WAIT_DONE
        do_reset();
        flog.delete();
        q0.push_back(8'hC3);
        wait_send("mid_send");
        bus.tx_active = 1'b1;
        tick();
        bus.tx_active = 1'b0;
        tick();
        chk("mid_pre_busy", bus.busy, 1'b1);
        reset_n = 1'b0;
        #1;
        chk("mid_send0", bus.tx_send,     1'b0);
        chk("mid_busy0", bus.busy,        1'b0);
        chk("mid_err0",  bus.err_timeout, 1'b0);
        chk("mid_data0", bus.tx_data,     8'h00);
        q0.delete(); q1.delete(); rdy_seen = 2'b00;
        tick(); tick();
        reset_n = 1'b1;
        tick();
        q1.push_back(8'h5A);
        xmit(0);
        tick();
        chk("mid_n",  flog.size(), 2);
        chk("mid_f1", flog[1], 9'h15A);

`ifdef TX_TIMEOUT_EN
        // Transmitter never starts: abort 16 cycles after SEND entry
        do_reset();
        flog.delete();
        q0.push_back(8'h88);
        wait_send("tmo_send");
        n = 0;
        while (bus.err_timeout !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk("tmo_cycles", n, TMO);
        chk("tmo_idle",   bus.busy,    1'b0);
        chk("tmo_send0",  bus.tx_send, 1'b0);
        q0.push_back(8'h8A);
        q1.push_back(8'h9B);
        #3;
        chk("tmo_next_rdy", bus.req_ready, 2'b10);
        tick();
        chk("tmo_pulse_len", bus.err_timeout, 1'b0);
        chk("tmo_next_gnt",  bus.grant_id,    1'b1);
        xmit(0);
        xmit(0);
        tick();
        chk("tmo_n",  flog.size(), 3);
        chk("tmo_f1", flog[1], 9'h19B);
        chk("tmo_f2", flog[2], 9'h08A);
`else
        // No abort: the frame waits indefinitely for the transmitter
        do_reset();
        q0.push_back(8'h66);
        wait_send("hold_send");
        repeat (40) tick();
        chk("hold_busy", bus.busy,        1'b1);
        chk("hold_send", bus.tx_send,     1'b1);
        chk("hold_err",  bus.err_timeout, 1'b0);
        xmit(0);
        chk("hold_idle", bus.busy, 1'b0);
`endif

        repeat (3) tick();
        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 4096, max cycles in SEND+WAIT_DONE before abort (used only when TX_TIMEOUT_EN is defined).
REQ-002 SHALL have port clock  input  1  system clock, single clock domain.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have ports req_valid  input  2  per-requester byte valid, index 0/1.
REQ-005 SHALL have ports req_data0, req_data1  input  8 each  per-requester byte.
REQ-006 SHALL have port req_ready  output  2  per-requester accept strobe.
REQ-007 SHALL have port tx_send  output  1  start request to the UART transmitter.
REQ-008 SHALL have port tx_data  output  8  byte presented to the transmitter.
REQ-009 SHALL have ports tx_active, tx_done  input  1 each  transmitter active and done flags.
REQ-010 SHALL have port grant_id  output  1  requester owning the current frame.
REQ-011 SHALL have port busy  output  1  high in any state except IDLE.
REQ-012 SHALL have port err_timeout  output  1  one-cycle abort pulse.

Function
REQ-013 SHALL implement FSM states IDLE, SEND, WAIT_DONE.
REQ-014 IDLE: if any req_valid, SHALL select the winner combinationally, assert req_ready for it only that cycle, latch its byte into tx_data and its index into grant_id, and go to SEND next cycle.
REQ-015 Both requests valid in the same cycle: SHALL grant the requester not granted last; last_grant resets to 1, so requester 0 wins the first contest.
REQ-016 req_ready SHALL be 0 outside IDLE and SHALL never be high on both bits.
REQ-017 SEND: SHALL hold tx_send=1 and tx_data stable until tx_active is sampled high, then go to WAIT_DONE with tx_send=0.
REQ-018 WAIT_DONE: SHALL go to IDLE when tx_done=1 and tx_active=0, and SHALL update last_grant on that transition.
REQ-019 tx_done high on entry to SEND, such as a stale done from the prior frame, SHALL be ignored; only WAIT_DONE evaluates tx_done.
REQ-020 A request arriving during SEND or WAIT_DONE SHALL wait; the requester holds valid and data (valid/ready rule), with no internal queue.
REQ-021 Minimum IDLE-to-IDLE frame turnaround is 3 cycles plus transmitter time; IDLE SHALL last exactly one cycle when a request is pending.
REQ-022 tx_data SHALL change only on an accept cycle.

Reset
REQ-023 reset_n low SHALL asynchronously force: state IDLE, tx_send 0, tx_data 0x00, req_ready 0, grant_id 0, busy 0, err_timeout 0, last_grant 1, timeout counter 0.
REQ-024 Reset mid-frame SHALL drop tx_send immediately, and the in-flight byte SHALL be discarded without an error pulse.

Configuration
REQ-025 With TX_TIMEOUT_EN defined: a counter SHALL clear on entering SEND, increment each cycle in SEND/WAIT_DONE, and on reaching TIMEOUT_CYCLES-1 SHALL force IDLE, drop tx_send, pulse err_timeout for one cycle, and update last_grant.
REQ-026 Without TX_TIMEOUT_EN: no counter SHALL be built, err_timeout SHALL be tied 0, and the FSM SHALL wait indefinitely.

Structure
REQ-027 A shared uart package SHALL hold the FSM state enum, requester count (2), and byte width (8).
REQ-028 Round-robin selection SHALL be one sub-module, uart_rr_pick (inputs req, last; outputs grant valid, index).

Verification
REQ-029 Single request: req_valid=01, data0=0xA5 -> req_ready=01 one cycle, tx_data=0xA5, tx_send high until tx_active, busy until done.
REQ-030 Contest: both valid from reset, data0=0x11, data1=0x22 -> frames sent 0x11 then 0x22; with both kept valid, grants alternate 0,1,0,1.
REQ-031 Stale done: tx_done held 1 through SEND, tx_active pulse after 10 cycles -> no early return to IDLE; exits only after active falls with done=1.
REQ-032 Reset mid-frame: reset_n low in WAIT_DONE -> tx_send=0, busy=0, err_timeout=0 immediately; next request is served normally.
REQ-033 Timeout (TX_TIMEOUT_EN, TIMEOUT_CYCLES=16): tx_active never rises -> err_timeout pulses exactly 16 cycles after SEND entry, FSM returns to IDLE, and the other requester wins next.
